// File: rtl/dcache_wt_pkg.sv
// Shared types for the write-through L1 data cache.
// Build with DCACHE_STATS_EN defined to add hit/miss counters.
package dcache_wt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } DCacheState;

    typedef logic [31:0] Data;
    typedef logic [31:0] DataAddr;

    // A one-word line still needs a 1-bit beat counter.
    function automatic int beat_w(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

endpackage

// File: rtl/dcache_store.sv
// Tag/valid/data arrays for dcache_wt: one line-word write port,
// combinational lookup, async reset and bulk clear of valid bits.
module dcache_store
    import dcache_wt_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic [$clog2(SETS)-1:0]       rd_index,
    input  logic [beat_w(LINE_WORDS)-1:0] rd_offset,
    output logic [TAG_W-1:0]              rd_tag,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          wr_en,
    input  logic [$clog2(SETS)-1:0]       wr_index,
    input  logic [beat_w(LINE_WORDS)-1:0] wr_offset,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          set_en,
    input  logic [TAG_W-1:0]              set_tag
);

    logic [DATA_WIDTH-1:0] data_q [SETS][LINE_WORDS];
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [SETS-1:0]       valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else if (set_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (set_en) begin
            tag_q[wr_index] <= set_tag;
        end
        if (wr_en) begin
            data_q[wr_index][wr_offset] <= wr_data;
        end
    end

    assign rd_tag   = tag_q[rd_index];
    assign rd_valid = valid_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Define DCACHE_STATS_EN to add saturating hit/miss counter ports.
module dcache_wt
    import dcache_wt_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_re,
    input  logic                  i_we,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_invalidate,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_hit,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_re,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
`ifdef DCACHE_STATS_EN
    output logic [31:0]           o_hit_count,
    output logic [31:0]           o_miss_count,
`endif
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_ready
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int OFFS_W  = $clog2(LINE_WORDS);
    localparam int TAG_W   = ADDR_WIDTH - INDEX_W - OFFS_W;
    localparam int BEAT_W  = beat_w(LINE_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    DCacheState state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    logic [TAG_W-1:0]      tag;
    logic [INDEX_W-1:0]    index;
    logic [BEAT_W-1:0]     offset;
    logic [ADDR_WIDTH-1:0] refill_addr;

    logic [TAG_W-1:0]      rd_tag;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_en;
    logic [BEAT_W-1:0]     wr_offset;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  set_en;
    logic                  clear;

    logic rd_req, wr_req, hit, last_beat, hit_now;

    assign tag   = i_addr[ADDR_WIDTH-1 -: TAG_W];
    assign index = i_addr[OFFS_W +: INDEX_W];

    generate
        if (OFFS_W > 0) begin : g_offs
            assign offset      = i_addr[OFFS_W-1:0];
            assign refill_addr = {i_addr[ADDR_WIDTH-1:OFFS_W], beat_q};
        end else begin : g_no_offs
            assign offset      = '0;
            assign refill_addr = i_addr;
        end
    endgenerate

    assign rd_req    = i_re && !i_we;
    assign wr_req    = i_we;
    assign hit       = rd_valid && (rd_tag == tag);
    assign last_beat = (beat_q == LAST_BEAT);

    dcache_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk       (i_clock),
        .rst_n     (i_reset),
        .clear     (clear),
        .rd_index  (index),
        .rd_offset (offset),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_index  (index),
        .wr_offset (wr_offset),
        .wr_data   (wr_data),
        .set_en    (set_en),
        .set_tag   (tag)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d = WRITE;
                end else if (rd_req && !hit) begin
                    state_d = REFILL;
                    beat_d  = '0;
                end
            end
            REFILL: begin
                if (i_mem_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end
                end
            end
            WRITE: begin
                if (i_mem_ready) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hit_now     = 1'b0;
        o_hit       = 1'b0;
        o_rdata     = '0;
        o_busy      = 1'b0;
        o_mem_addr  = '0;
        o_mem_re    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        wr_en       = 1'b0;
        wr_offset   = offset;
        wr_data     = i_wdata;
        set_en      = 1'b0;
        clear       = 1'b0;
        unique case (state_q)
            IDLE: begin
                hit_now = rd_req && hit;
                o_hit   = hit_now;
                o_rdata = hit_now ? rd_data : '0;
                o_busy  = wr_req || (rd_req && !hit);
                clear   = i_invalidate && !rd_req && !wr_req;
            end
            REFILL: begin
                o_busy     = 1'b1;
                o_mem_re   = 1'b1;
                o_mem_addr = refill_addr;
                wr_en      = i_mem_ready;
                wr_offset  = beat_q;
                wr_data    = i_mem_rdata;
                set_en     = i_mem_ready && last_beat;
            end
            WRITE: begin
                o_busy      = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = i_addr;
                o_mem_wdata = i_wdata;
                // no allocate: only a resident line picks up the store
                wr_en       = i_mem_ready && hit;
            end
            DONE: ;
            default: ;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic miss_inc;

    assign miss_inc = (state_q == IDLE) && (state_d == REFILL);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_hit_count  <= '0;
            o_miss_count <= '0;
        end else begin
            if (hit_now && (o_hit_count != '1)) begin
                o_hit_count <= o_hit_count + 1'b1;
            end
            if (miss_inc && (o_miss_count != '1)) begin
                o_miss_count <= o_miss_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Directed plus randomized bench for dcache_wt against a line-presence
// model and a word-addressed memory model.
module tb_dcache_wt;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int SETS = 64;
    localparam int LW   = 4;

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_re = 1'b0;
    logic          i_we = 1'b0;
    logic [DW-1:0] i_wdata = '0;
    logic          i_invalidate = 1'b0;
    logic [DW-1:0] o_rdata;
    logic          o_hit;
    logic          o_busy;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_re;
    logic          o_mem_we;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata = '0;
    logic          i_mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0]   o_hit_count;
    logic [31:0]   o_miss_count;
`endif

    dcache_wt #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SETS       (SETS),
        .LINE_WORDS (LW)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_addr       (i_addr),
        .i_re         (i_re),
        .i_we         (i_we),
        .i_wdata      (i_wdata),
        .i_invalidate (i_invalidate),
        .o_rdata      (o_rdata),
        .o_hit        (o_hit),
        .o_busy       (o_busy),
        .o_mem_addr   (o_mem_addr),
        .o_mem_re     (o_mem_re),
        .o_mem_we     (o_mem_we),
        .o_mem_wdata  (o_mem_wdata),
`ifdef DCACHE_STATS_EN
        .o_hit_count  (o_hit_count),
        .o_miss_count (o_miss_count),
`endif
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_ready  (i_mem_ready)
    );

    always #5 i_clock = ~i_clock;

    int checks = 0;
    int failures = 0;

    // memory model and transfer logs
    logic [DW-1:0] mem [int unsigned];
    int unsigned   rd_log[$];
    int unsigned   wr_log[$];
    int            mem_delay = 0;
    int            wait_cnt = 0;

    // cache model: which line number sits in each set
    bit            present [SETS];
    int unsigned   line_of [SETS];
    int            exp_hits = 0;
    int            exp_misses = 0;

    function automatic logic [DW-1:0] mem_rd(input int unsigned a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
    endfunction

    function automatic bit model_hit(input int unsigned a);
        int unsigned s;
        s = (a / LW) % SETS;
        return present[s] && (line_of[s] == a / LW);
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) present[s] = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge i_clock) begin
        if (!i_reset) begin
            wait_cnt    = 0;
            i_mem_ready = 1'b0;
        end else if (o_mem_re || o_mem_we) begin
            if (wait_cnt >= mem_delay) begin
                i_mem_ready = 1'b1;
                wait_cnt    = 0;
                if (o_mem_re) begin
                    i_mem_rdata = mem_rd(o_mem_addr);
                    rd_log.push_back(o_mem_addr);
                end else begin
                    mem[o_mem_addr] = o_mem_wdata;
                    wr_log.push_back(o_mem_addr);
                end
            end else begin
                i_mem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            i_mem_ready = 1'b0;
            wait_cnt    = 0;
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_hit"}, o_hit, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_mre"}, o_mem_re, 0);
        chk({tag, "_mwe"}, o_mem_we, 0);
        chk({tag, "_rdata"}, o_rdata, 0);
        chk({tag, "_maddr"}, o_mem_addr, 0);
        chk({tag, "_mwdata"}, o_mem_wdata, 0);
`ifdef DCACHE_STATS_EN
        chk({tag, "_hitcnt"}, o_hit_count, 0);
        chk({tag, "_misscnt"}, o_miss_count, 0);
`endif
    endtask

    task automatic do_read(input int unsigned a, input int dly);
        bit exp_hit;
        bit ok;
        bit both;
        int busy_n;
        exp_hit = model_hit(a);
        mem_delay = dly;
        rd_log.delete();
        wr_log.delete();
        i_addr = a;
        i_re = 1'b1;
        i_we = 1'b0;
        busy_n = 0;
        both = 1'b0;
        @(negedge i_clock);
        chk("rd_first_busy", o_busy, !exp_hit);
        while (o_busy && busy_n < 100) begin
            busy_n++;
            if (o_mem_re && o_mem_we) both = 1'b1;
            @(negedge i_clock);
        end
        chk("rd_hit", o_hit, 1);
        chk("rd_data", o_rdata, mem_rd(a));
        chk("rd_latency", busy_n, exp_hit ? 0 : 1 + LW * (dly + 1));
        chk("rd_no_both", both, 0);
        chk("rd_no_wr", wr_log.size(), 0);
        ok = (rd_log.size() == (exp_hit ? 0 : LW));
        if (ok && !exp_hit)
            for (int i = 0; i < LW; i++)
                if (rd_log[i] != (a / LW) * LW + i) ok = 1'b0;
        chk("rd_beats", ok, 1);
        @(posedge i_clock);
        #1;
        i_re = 1'b0;
        present[(a / LW) % SETS] = 1'b1;
        line_of[(a / LW) % SETS] = a / LW;
        exp_hits++;
        if (!exp_hit) exp_misses++;
    endtask

    task automatic do_write(input int unsigned a, input logic [DW-1:0] d,
                            input int dly);
        int busy_n;
        int we_n;
        bit re_seen;
        mem_delay = dly;
        rd_log.delete();
        wr_log.delete();
        i_addr = a;
        i_wdata = d;
        i_we = 1'b1;
        i_re = 1'b0;
        busy_n = 0;
        we_n = 0;
        re_seen = 1'b0;
        @(negedge i_clock);
        while (o_busy && busy_n < 100) begin
            busy_n++;
            if (o_mem_we) we_n++;
            if (o_mem_re) re_seen = 1'b1;
            @(negedge i_clock);
        end
        chk("wr_busy_cycles", busy_n, dly + 2);
        chk("wr_we_cycles", we_n, dly + 1);
        chk("wr_no_re", re_seen, 0);
        chk("wr_count", wr_log.size(), 1);
        if (wr_log.size() == 1) chk("wr_addr", wr_log[0], a);
        chk("wr_mem_data", mem_rd(a), d);
        chk("wr_done_idle", o_mem_we, 0);
        @(posedge i_clock);
        #1;
        i_we = 1'b0;
    endtask

    task automatic do_inval();
        i_invalidate = 1'b1;
        @(posedge i_clock);
        #1;
        i_invalidate = 1'b0;
        model_clear();
    endtask

    initial begin
        int unsigned a;
        int r;
        model_clear();

        repeat (2) @(negedge i_clock);
        chk_reset_outs("reset");
        @(posedge i_clock);
        #1;
        i_reset = 1'b1;

        do_read(32'h100, 0);
        do_read(32'h101, 0);
        do_write(32'h102, 32'hDEAD_BEEF, 3);
        do_read(32'h102, 0);
        chk("rd_102_value", o_rdata, 32'hDEAD_BEEF);

        do_write(32'h900, 32'h1234_5678, 1);
        chk("wr_miss_no_alloc", model_hit(32'h900), 0);
        do_read(32'h900, 0);

        // reset while the third beat of a refill is outstanding
        mem_delay = 0;
        rd_log.delete();
        i_addr = 32'h200;
        i_re = 1'b1;
        for (int n = 0; n < 20 && rd_log.size() < 2; n++) @(negedge i_clock);
        chk("mid_refill_beats", rd_log.size(), 2);
        @(posedge i_clock);
        #2;
        i_reset = 1'b0;
        i_re = 1'b0;
        model_clear();
        exp_hits = 0;
        exp_misses = 0;
        @(negedge i_clock);
        chk_reset_outs("mid_reset");
        @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        do_read(32'h200, 1);
        do_read(32'h203, 0);

        do_read(32'h300, 2);
        do_read(32'h301, 0);
        do_inval();
        do_read(32'h300, 0);
        do_read(32'h203, 0);
`ifdef DCACHE_STATS_EN
        @(negedge i_clock);
        chk("stats_hits", o_hit_count, exp_hits);
        chk("stats_misses", o_miss_count, exp_misses);
`endif

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 99);
            a = $urandom_range(0, 2) * SETS * LW
              + $urandom_range(0, 3) * LW
              + $urandom_range(0, LW - 1);
            if (r < 6) do_inval();
            else if (r < 35) do_write(a, $urandom, $urandom_range(0, 2));
            else do_read(a, $urandom_range(0, 2));
        end

`ifdef DCACHE_STATS_EN
        @(negedge i_clock);
        chk("stats_hits_end", o_hit_count, exp_hits);
        chk("stats_misses_end", o_miss_count, exp_misses);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
